// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle scan path.
package raster_pkg;

   localparam int unsigned COORD_W = 9;
   localparam int unsigned FRAG_W  = 17;

   localparam int unsigned X_IDX = 2;
   localparam int unsigned Y_IDX = 1;
   localparam int unsigned Z_IDX = 0;

   typedef logic [2:0][COORD_W-1:0] vertex_t;

   typedef enum logic [2:0] {
      StIdle,
      StBbox,
      StIssue,
      StWait,
      StEmit,
      StDone
   } state_e;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

endpackage

// File: rtl/bbox_clip.sv
// Bounding box of three vertices, upper corner clipped to the screen.
module bbox_clip
   import raster_pkg::*;
#(
   parameter int unsigned H_RES = 320,
   parameter int unsigned V_RES = 240
) (
   input  logic [COORD_W-1:0] x1_i,
   input  logic [COORD_W-1:0] x2_i,
   input  logic [COORD_W-1:0] x3_i,
   input  logic [COORD_W-1:0] y1_i,
   input  logic [COORD_W-1:0] y2_i,
   input  logic [COORD_W-1:0] y3_i,
   output logic [COORD_W-1:0] xmin_o,
   output logic [COORD_W-1:0] xmax_o,
   output logic [COORD_W-1:0] ymin_o,
   output logic [COORD_W-1:0] ymax_o,
   output logic               empty_o
);

   localparam logic [COORD_W-1:0] XLim = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] YLim = COORD_W'(V_RES - 1);

   logic [COORD_W-1:0] xmax_raw;
   logic [COORD_W-1:0] ymax_raw;

   always_comb begin
      xmin_o   = min3(x1_i, x2_i, x3_i);
      ymin_o   = min3(y1_i, y2_i, y3_i);
      xmax_raw = max3(x1_i, x2_i, x3_i);
      ymax_raw = max3(y1_i, y2_i, y3_i);
      xmax_o   = (xmax_raw > XLim) ? XLim : xmax_raw;
      ymax_o   = (ymax_raw > YLim) ? YLim : ymax_raw;
      // A lower corner beyond the clipped upper corner means nothing is on screen.
      empty_o  = (xmin_o > xmax_o) || (ymin_o > ymax_o);
   end

endmodule

// File: rtl/tri_scan.sv
// Walks the clipped bounding box of one triangle, queries the in-triangle tester per
// pixel and streams covered pixels out as fragments.
module tri_scan
   import raster_pkg::*;
#(
   parameter int unsigned H_RES = 320,
   parameter int unsigned V_RES = 240
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  vertex_t            v1,
   input  vertex_t            v2,
   input  vertex_t            v3,
   input  logic               tri_valid,
   output logic               tri_ready,
   output vertex_t            q_v1,
   output vertex_t            q_v2,
   output vertex_t            q_v3,
   output logic [COORD_W-1:0] q_x,
   output logic [COORD_W-1:0] q_y,
   output logic               q_valid,
   input  logic               r_in_tri,
   input  logic               r_valid,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [FRAG_W-1:0]  frag_count,
   output logic               done
);

   state_e state_q, state_d;

   vertex_t            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [FRAG_W-1:0]  frag_q, frag_d;

   logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic               bb_empty;
   logic               accept, advance, x_end, y_end, last_pix;

   bbox_clip #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_bbox_clip (
      .x1_i    (v1_q[X_IDX]),
      .x2_i    (v2_q[X_IDX]),
      .x3_i    (v3_q[X_IDX]),
      .y1_i    (v1_q[Y_IDX]),
      .y2_i    (v2_q[Y_IDX]),
      .y3_i    (v3_q[Y_IDX]),
      .xmin_o  (bb_xmin),
      .xmax_o  (bb_xmax),
      .ymin_o  (bb_ymin),
      .ymax_o  (bb_ymax),
      .empty_o (bb_empty)
   );

   assign accept   = (state_q == StIdle) && tri_valid;
   assign x_end    = (x_q >= xmax_q);
   assign y_end    = (y_q >= ymax_q);
   assign last_pix = x_end && y_end;
   // Cursor moves on a miss verdict or once a covered pixel is taken by the writer.
   assign advance  = ((state_q == StWait) && r_valid && !r_in_tri) ||
                     ((state_q == StEmit) && pix_ready);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (tri_valid) state_d = StBbox;
         StBbox:  state_d = bb_empty ? StDone : StIssue;
         StIssue: state_d = StWait;
         StWait: begin
            if (r_valid) begin
               if (r_in_tri)      state_d = StEmit;
               else if (last_pix) state_d = StDone;
               else               state_d = StIssue;
            end
         end
         StEmit: begin
            if (pix_ready) state_d = last_pix ? StDone : StIssue;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tri_ready = (state_q == StIdle) && !rst_in;
      q_valid   = (state_q == StIssue);
      pix_valid = (state_q == StEmit);
      done      = (state_q == StDone);
   end

   assign q_x        = x_q;
   assign q_y        = y_q;
   assign pix_x      = x_q;
   assign pix_y      = y_q;
   assign q_v1       = v1_q;
   assign q_v2       = v2_q;
   assign q_v3       = v3_q;
   assign frag_count = frag_q;

   always_comb begin
      v1_d   = v1_q;
      v2_d   = v2_q;
      v3_d   = v3_q;
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymin_d = ymin_q;
      ymax_d = ymax_q;
      x_d    = x_q;
      y_d    = y_q;
      frag_d = frag_q;
      if (accept) begin
         v1_d   = v1;
         v2_d   = v2;
         v3_d   = v3;
         frag_d = '0;
      end
      if ((state_q == StBbox) && !bb_empty) begin
         xmin_d = bb_xmin;
         xmax_d = bb_xmax;
         ymin_d = bb_ymin;
         ymax_d = bb_ymax;
         x_d    = bb_xmin;
         y_d    = bb_ymin;
      end
      if (advance) begin
         if (!x_end) begin
            x_d = x_q + COORD_W'(1);
         end else if (!y_end) begin
            x_d = xmin_q;
            y_d = y_q + COORD_W'(1);
         end
      end
      if ((state_q == StEmit) && pix_ready) begin
         frag_d = frag_q + FRAG_W'(1);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         v1_q   <= '0;
         v2_q   <= '0;
         v3_q   <= '0;
         xmin_q <= '0;
         xmax_q <= '0;
         ymin_q <= '0;
         ymax_q <= '0;
         x_q    <= '0;
         y_q    <= '0;
         frag_q <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymin_q <= ymin_d;
         ymax_q <= ymax_d;
         x_q    <= x_d;
         y_q    <= y_d;
         frag_q <= frag_d;
      end
   end

endmodule

// File: tb/tb_tri_scan.sv
// Directed and randomized triangles against an edge-function coverage model, with a
// 3-cycle tester model and a randomly stalling fragment writer.
module tb_tri_scan;
   import raster_pkg::*;

   localparam int H_RES = 320;
   localparam int V_RES = 240;

   logic               clk_in = 1'b0;
   logic               rst_in;
   vertex_t            v1, v2, v3, q_v1, q_v2, q_v3;
   logic               tri_valid, tri_ready;
   logic [COORD_W-1:0] q_x, q_y, pix_x, pix_y;
   logic               q_valid, done, pix_valid;
   logic               r_in_tri = 1'b0;
   logic               r_valid = 1'b0;
   logic               pix_ready = 1'b1;
   logic [FRAG_W-1:0]  frag_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bit hold_low = 0;
   bit ready_rand = 0;

   // Monitor logs
   int q_cnt, done_cnt, first_q_cyc, done_cyc;
   int qx_log[$], qy_log[$], qc_log[$], fx_log[$], fy_log[$];
   bit stall_prev = 0;
   int sx, sy;

   // Tester model: pending responses (due cycle, verdict)
   int due_q[$];
   bit vd_q[$];

   vertex_t tv1, tv2, tv3;
   int      t_acc;

   tri_scan #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .v1         (v1),
      .v2         (v2),
      .v3         (v3),
      .tri_valid  (tri_valid),
      .tri_ready  (tri_ready),
      .q_v1       (q_v1),
      .q_v2       (q_v2),
      .q_v3       (q_v3),
      .q_x        (q_x),
      .q_y        (q_y),
      .q_valid    (q_valid),
      .r_in_tri   (r_in_tri),
      .r_valid    (r_valid),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .frag_count (frag_count),
      .done       (done)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   function automatic bit covers(input int px, input int py, input int ax, input int ay,
                                 input int bx, input int by, input int cx, input int cy);
      int e0, e1, e2;
      e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
      e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
      e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
      return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
   endfunction

   function automatic vertex_t mkv(input int x, input int y, input int z);
      vertex_t v;
      v[X_IDX] = COORD_W'(x);
      v[Y_IDX] = COORD_W'(y);
      v[Z_IDX] = COORD_W'(z);
      return v;
   endfunction

   // Tester answers each query exactly three cycles after its strobe.
   always @(posedge clk_in) begin
      #1;
      r_valid  = 1'b0;
      r_in_tri = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         r_valid  = 1'b1;
         r_in_tri = vd_q[0];
         void'(due_q.pop_front());
         void'(vd_q.pop_front());
      end
   end

   always @(posedge clk_in) begin
      #1;
      pix_ready = hold_low ? 1'b0 : (ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
   end

   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (q_valid) begin
            if (q_cnt == 0) first_q_cyc = cyc;
            q_cnt++;
            qx_log.push_back(int'(q_x));
            qy_log.push_back(int'(q_y));
            qc_log.push_back(cyc);
            due_q.push_back(cyc + 3);
            vd_q.push_back(covers(int'(q_x), int'(q_y),
                                  int'(q_v1[X_IDX]), int'(q_v1[Y_IDX]),
                                  int'(q_v2[X_IDX]), int'(q_v2[Y_IDX]),
                                  int'(q_v3[X_IDX]), int'(q_v3[Y_IDX])));
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (stall_prev) begin
            check("pix_hold_valid", 32'(pix_valid), 32'd1);
            check("pix_hold_x", 32'(pix_x), 32'(sx));
            check("pix_hold_y", 32'(pix_y), 32'(sy));
         end
         if (pix_valid && pix_ready) begin
            fx_log.push_back(int'(pix_x));
            fy_log.push_back(int'(pix_y));
         end
         stall_prev = pix_valid && !pix_ready;
         sx = int'(pix_x);
         sy = int'(pix_y);
      end else begin
         stall_prev = 0;
      end
   end

   task automatic clear_logs();
      q_cnt = 0;
      done_cnt = 0;
      first_q_cyc = -1;
      done_cyc = -1;
      qx_log.delete();
      qy_log.delete();
      qc_log.delete();
      fx_log.delete();
      fy_log.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tri_ready"}, 32'(tri_ready), 32'd0);
      check({tag, "_q_valid"}, 32'(q_valid), 32'd0);
      check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_qxy"}, 32'({q_x, q_y}), 32'd0);
      check({tag, "_pixxy"}, 32'({pix_x, pix_y}), 32'd0);
      check({tag, "_frag_count"}, 32'(frag_count), 32'd0);
      check({tag, "_q_v1"}, 32'(q_v1), 32'd0);
      check({tag, "_q_v23"}, 32'(q_v2 | q_v3), 32'd0);
   endtask

   // keep=1 leaves tri_valid high with junk vertices while the triangle is busy.
   task automatic start_tri(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy, input bit keep);
      int n = 0;
      tv1 = mkv(ax, ay, $urandom_range(0, 511));
      tv2 = mkv(bx, by, $urandom_range(0, 511));
      tv3 = mkv(cx, cy, $urandom_range(0, 511));
      clear_logs();
      while (!tri_ready && n < 100) begin
         step();
         n++;
      end
      v1 = tv1;
      v2 = tv2;
      v3 = tv3;
      tri_valid = 1'b1;
      t_acc = cyc;
      step();
      check("busy_tri_ready", 32'(tri_ready), 32'd0);
      if (keep) begin
         v1 = mkv(1, 2, 3);
         v2 = mkv(4, 5, 6);
         v3 = mkv(7, 8, 9);
      end else begin
         tri_valid = 1'b0;
      end
   endtask

   task automatic finish_tri(input string tag, input int budget);
      int ax, ay, bx, by, cx, cy, xmin, xmax, ymin, ymax, n;
      int eqx[$], eqy[$], efx[$], efy[$];
      bit ecov[$];
      bit c;
      ax = int'(tv1[X_IDX]); ay = int'(tv1[Y_IDX]);
      bx = int'(tv2[X_IDX]); by = int'(tv2[Y_IDX]);
      cx = int'(tv3[X_IDX]); cy = int'(tv3[Y_IDX]);
      xmin = (ax < bx) ? ax : bx;  xmin = (cx < xmin) ? cx : xmin;
      ymin = (ay < by) ? ay : by;  ymin = (cy < ymin) ? cy : ymin;
      xmax = (ax > bx) ? ax : bx;  xmax = (cx > xmax) ? cx : xmax;
      ymax = (ay > by) ? ay : by;  ymax = (cy > ymax) ? cy : ymax;
      if (xmax > H_RES - 1) xmax = H_RES - 1;
      if (ymax > V_RES - 1) ymax = V_RES - 1;
      for (int y = ymin; y <= ymax; y++) begin
         for (int x = xmin; x <= xmax; x++) begin
            c = covers(x, y, ax, ay, bx, by, cx, cy);
            eqx.push_back(x);
            eqy.push_back(y);
            ecov.push_back(c);
            if (c) begin
               efx.push_back(x);
               efy.push_back(y);
            end
         end
      end
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      tri_valid = 1'b0;
      check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
      step();
      step();
      check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      check({tag, "_queries"}, 32'(q_cnt), 32'(eqx.size()));
      check({tag, "_frags"}, 32'(fx_log.size()), 32'(efx.size()));
      check({tag, "_frag_count"}, 32'(frag_count), 32'(efx.size()));
      check({tag, "_q_v1"}, 32'(q_v1), 32'(tv1));
      check({tag, "_q_v3"}, 32'(q_v3), 32'(tv3));
      if (eqx.size() == 0) check({tag, "_done_cyc"}, 32'(done_cyc), 32'(t_acc + 2));
      else                 check({tag, "_first_q"}, 32'(first_q_cyc), 32'(t_acc + 2));
      for (int i = 0; i < eqx.size() && i < qx_log.size(); i++) begin
         check({tag, "_qxy"}, 32'(qx_log[i] * 512 + qy_log[i]), 32'(eqx[i] * 512 + eqy[i]));
         if (!ecov[i] && i + 1 < qc_log.size())
            check({tag, "_miss_gap"}, 32'(qc_log[i + 1] - qc_log[i]), 32'd4);
      end
      for (int i = 0; i < efx.size() && i < fx_log.size(); i++)
         check({tag, "_fxy"}, 32'(fx_log[i] * 512 + fy_log[i]), 32'(efx[i] * 512 + efy[i]));
   endtask

   initial begin
      int q0, n, bx0, by0;
      rst_in = 1'b1;
      tri_valid = 1'b0;
      v1 = '0;
      v2 = '0;
      v3 = '0;
      clear_logs();
      #2;
      check_reset_outputs("por");
      step();
      step();
      rst_in = 1'b0;
      #1;
      check("por_release_ready", 32'(tri_ready), 32'd1);

      start_tri(10, 10, 13, 10, 10, 13, 0);
      finish_tri("tri16", 2000);

      start_tri(5, 7, 5, 7, 5, 7, 0);
      finish_tri("single", 200);

      start_tri(330, 10, 400, 50, 360, 90, 0);
      finish_tri("offscreen", 200);

      start_tri(300, 200, 400, 200, 300, 260, 0);
      finish_tri("clip800", 10000);

      // Writer stalls on the first fragment: no further queries may go out.
      hold_low = 1;
      start_tri(10, 10, 13, 10, 10, 13, 0);
      n = 0;
      while (!pix_valid && n < 50) begin
         step();
         n++;
      end
      check("stall_pix_valid", 32'(pix_valid), 32'd1);
      q0 = q_cnt;
      repeat (10) step();
      check("stall_no_query", 32'(q_cnt), 32'(q0));
      check("stall_xy", 32'({pix_x, pix_y}), 32'({9'd10, 9'd10}));
      hold_low = 0;
      finish_tri("stall", 2000);

      // Reset while a query is outstanding; its response then lands in IDLE.
      start_tri(10, 10, 13, 10, 10, 13, 0);
      n = 0;
      while (q_cnt == 0 && n < 20) begin
         step();
         n++;
      end
      rst_in = 1'b1;
      #1;
      check_reset_outputs("midrst");
      step();
      rst_in = 1'b0;
      clear_logs();
      repeat (6) step();
      check("stale_no_query", 32'(q_cnt), 32'd0);
      check("stale_no_done", 32'(done_cnt), 32'd0);
      check("stale_no_frag", 32'(fx_log.size()), 32'd0);
      check("stale_idle", 32'(tri_ready), 32'd1);
      start_tri(20, 30, 24, 33, 19, 36, 0);
      finish_tri("after_rst", 2000);

      // Randomized triangles with a randomly stalling writer.
      ready_rand = 1;
      for (int t = 0; t < 8; t++) begin
         bx0 = $urandom_range(0, 330);
         by0 = $urandom_range(0, 250);
         start_tri(bx0 + $urandom_range(0, 6), by0 + $urandom_range(0, 6),
                   bx0 + $urandom_range(0, 6), by0 + $urandom_range(0, 6),
                   bx0 + $urandom_range(0, 6), by0 + $urandom_range(0, 6), t[0]);
         finish_tri("rand", 2000);
      end
      ready_rand = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tri_scan.md
# tri_scan

Triangle scan initiator for the rasterizer. Accepts one screen-space triangle, computes its bounding box clipped to the screen, and walks it pixel by pixel. For each pixel it issues one point-in-triangle query to the existing in-triangle tester and collects the single-bit verdict. Covered pixels are emitted on a back-pressured fragment stream to the framebuffer writer.

## Interface
Parameters:
- H_RES, 320, screen width in pixels; x clipped to [0, H_RES-1]
- V_RES, 240, screen height in pixels; y clipped to [0, V_RES-1]

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- v1, v2, v3  input  9 x [2:0] each  vertices; [2]=x, [1]=y, [0]=z (z unused here, forwarded to tester)
- tri_valid  input  1  triangle present on v1..v3
- tri_ready  output  1  high only in IDLE; triangle accepted when tri_valid & tri_ready
- q_v1, q_v2, q_v3  output  9 x [2:0] each  latched vertices to tester, stable for whole triangle
- q_x, q_y  output  9  query pixel, stable from issue until response
- q_valid  output  1  one-cycle query strobe
- r_in_tri  input  1  tester verdict
- r_valid  input  1  tester response strobe
- pix_x, pix_y  output  9  covered pixel
- pix_valid  output  1  fragment valid; held until pix_ready
- pix_ready  input  1  writer accepts fragment
- frag_count  output  17  covered pixels emitted for current/last triangle
- done  output  1  one-cycle pulse after last pixel of triangle

## Operation
- States: IDLE, BBOX, ISSUE, WAIT, EMIT, DONE.
- IDLE: tri_ready=1. On handshake latch v1..v3, clear frag_count, go BBOX.
- BBOX: xmin/xmax = min/max of vertex x; ymin/ymax likewise. Clip xmax to H_RES-1, ymax to V_RES-1. If xmin>xmax or ymin>ymax (off-screen): go DONE. Else set cursor (x,y)=(xmin,ymin), go ISSUE.
- ISSUE: q_valid=1 for exactly this cycle, q_x/q_y=cursor; go WAIT.
- WAIT: on r_valid: if r_in_tri go EMIT, else advance cursor. r_valid in any other state is ignored.
- EMIT: pix_valid=1, pix_x/pix_y=cursor. On pix_ready: frag_count+1, advance cursor.
- Advance: if x<xmax then x+1, go ISSUE. Else if y<ymax then x=xmin, y+1, go ISSUE. Else go DONE.
- DONE: done=1 for one cycle; go IDLE. frag_count holds until next accepted triangle.
- All compares unsigned 9-bit; cursor never exceeds the clipped bbox, so there is no wrap-around.
- Only one query is outstanding at a time; the tester is never re-strobed before its response.

## Timing
- Reset: state IDLE; tri_ready=0 during reset, 1 on first cycle after release; q_valid, pix_valid, done=0; q_x, q_y, pix_x, pix_y, frag_count, q_v* = 0.
- Reset asserted mid-triangle aborts immediately. No done pulse, no fragment is emitted.
- Accept at cycle T: BBOX at T+1, first q_valid at T+2.
- Per pixel: ISSUE (1 cycle) + tester latency (3 cycles for current tester) + 0 or 1 extra cycle. Uncovered pixel: next ISSUE the cycle after r_valid. Covered pixel with pix_ready high: EMIT 1 cycle, then ISSUE.
- pix_valid, pix_x, pix_y must not change while pix_valid & !pix_ready.
- Off-screen triangle: done at T+2, frag_count=0.
- tri_valid during non-IDLE is ignored (not accepted).

## Structure
- Package raster_pkg: COORD_W=9, vertex typedef (9-bit x [2:0]), vertex index constants X_IDX=2, Y_IDX=1, Z_IDX=0, state enum.
- Sub-module bbox_clip: combinational min3/max3 plus clip. Its outputs are registered in BBOX.
- The in-triangle tester is instantiated beside tri_scan at the top level, not inside it.

## Test plan
- Triangle (10,10),(13,10),(10,13): bbox 4x4, 16 queries. Bench tester model with 3-cycle latency. Expect exactly the modeled-covered pixels in raster order, frag_count equal to their count, one done.
- Single-pixel triangle, all vertices (5,7): one q_valid with q_x=5, q_y=7. Verdict 1 gives one fragment (5,7), frag_count=1, done.
- Vertices x in 330..400: off-screen. Expect no q_valid, done at T+2, frag_count=0.
- Vertices (300,200),(400,200),(300,260): queries limited to x 300..319, y 200..239; 800 queries total.
- pix_ready held low 10 cycles on the first fragment: pix_valid and coordinates stable, no new q_valid until accepted.
- rst_in pulsed during WAIT of a 16-pixel triangle: all outputs 0 asynchronously. Next triangle processes normally, and a stale r_valid arriving in IDLE is ignored.
